// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divide/remainder engine.
package div_pkg;

   localparam int LENGTH   = 32;
   localparam int DIV_ITER = 32;

   localparam logic OP_DIV = 1'b0;
   localparam logic OP_REM = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   // Two's-complement negate a magnitude when neg is set.
   function automatic logic [LENGTH-1:0] apply_sign(input logic [LENGTH-1:0] mag,
                                                     input logic              neg);
      return neg ? (~mag + LENGTH'(1)) : mag;
   endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_if;
   import div_pkg::*;

   logic              enable_div;
   logic              operation;
   logic [LENGTH-1:0] oper_a;
   logic [LENGTH-1:0] oper_b;
   logic [LENGTH-1:0] div_o;
   logic              div_busy;
   logic              div_valid;

   modport master (
      output enable_div, operation, oper_a, oper_b,
      input  div_o, div_busy, div_valid
   );

   modport slave (
      input  enable_div, operation, oper_a, oper_b,
      output div_o, div_busy, div_valid
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it does not go negative.
module div_step
   import div_pkg::*;
(
   input  logic [LENGTH-1:0] rem_i,
   input  logic              bit_i,
   input  logic [LENGTH:0]   div_i,
   output logic [LENGTH-1:0] rem_o,
   output logic              q_o
);

   logic [LENGTH:0] shifted;

   // Trial subtraction in LENGTH+1 bits so a 2^31 divisor compares correctly.
   always_comb begin
      shifted = {rem_i, bit_i};
      q_o     = (shifted >= div_i);
      rem_o   = q_o ? LENGTH'(shifted - div_i) : shifted[LENGTH-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Sequential signed RV32M DIV/REM engine, 33-cycle fixed latency.
// Build option: DIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and
// |a| < |b| skip the iterations and complete one cycle after accept.
//
// state | meaning
// IDLE  | waiting for enable_div; div_busy low
// CALC  | one restoring iteration per cycle, 32 in total
// DONE  | sign-correct, apply special cases, pulse div_valid
module div_unit
   import div_pkg::*;
(
   input logic  clk,
   input logic  rst_n,
   div_if.slave bus
);

   div_state_t        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [LENGTH-1:0] rem_q, rem_d;
   logic [LENGTH-1:0] dvd_q, dvd_d;
   logic [LENGTH:0]   b_mag_q, b_mag_d;
   logic              op_q, op_d;
   logic              q_sign_q, q_sign_d;
   logic              r_sign_q, r_sign_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;
   logic [LENGTH-1:0] div_o_q, div_o_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;

   logic [LENGTH-1:0] a_abs;
   logic [LENGTH:0]   b_abs;
   logic              dz_in;
   logic              ovf_in;
   logic [LENGTH-1:0] step_rem;
   logic              step_q;

   div_step u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[LENGTH-1]),
      .div_i (b_mag_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Operand magnitudes and special-case detection on the request inputs.
   always_comb begin
      a_abs  = bus.oper_a[LENGTH-1] ? (LENGTH'(0) - bus.oper_a) : bus.oper_a;
      b_abs  = bus.oper_b[LENGTH-1] ? ((LENGTH+1)'(0) - {1'b1, bus.oper_b})
                                    : {1'b0, bus.oper_b};
      dz_in  = (bus.oper_b == '0);
      ovf_in = (bus.oper_a == {1'b1, {(LENGTH-1){1'b0}}}) && (bus.oper_b == '1);
   end

   // Next-state and datapath updates for the FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      b_mag_d  = b_mag_q;
      op_d     = op_q;
      q_sign_d = q_sign_q;
      r_sign_d = r_sign_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      div_o_d  = div_o_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.enable_div) begin
               busy_d   = 1'b1;
               op_d     = bus.operation;
               q_sign_d = bus.oper_a[LENGTH-1] ^ bus.oper_b[LENGTH-1];
               r_sign_d = bus.oper_a[LENGTH-1];
               dvd_d    = a_abs;
               b_mag_d  = b_abs;
               dz_d     = dz_in;
               ovf_d    = ovf_in;
               rem_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
               // Results here are known without iterating: quotient 0 and
               // remainder |a|, except overflow whose remainder is 0.
               if (dz_in || ovf_in || ({1'b0, a_abs} < b_abs)) begin
                  rem_d   = ovf_in ? '0 : a_abs;
                  dvd_d   = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[LENGTH-2:0], step_q};
            if (cnt_q == 5'(DIV_ITER - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DONE: begin
            if (dz_q) begin
               div_o_d = (op_q == OP_DIV) ? '1 : apply_sign(rem_q, r_sign_q);
            end else if (ovf_q) begin
               div_o_d = (op_q == OP_DIV) ? {1'b1, {(LENGTH-1){1'b0}}} : '0;
            end else begin
               div_o_d = (op_q == OP_DIV) ? apply_sign(dvd_q, q_sign_q)
                                          : apply_sign(rem_q, r_sign_q);
            end
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         b_mag_q  <= '0;
         op_q     <= OP_DIV;
         q_sign_q <= 1'b0;
         r_sign_q <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         div_o_q  <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         b_mag_q  <= b_mag_d;
         op_q     <= op_d;
         q_sign_q <= q_sign_d;
         r_sign_q <= r_sign_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         div_o_q  <= div_o_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.div_o     = div_o_q;
   assign bus.div_busy  = busy_q;
   assign bus.div_valid = valid_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, handshake timing, ignored requests,
// async reset abort and back-to-back throughput.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_BUILD = 1'b1;
`else
   localparam bit EARLY_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t_first;
   int   seen_valid;

   div_if bus ();

   div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request at the current negedge and follow it to completion,
   // checking busy/valid every cycle. Returns at the negedge after the
   // valid edge. A poke at cycle k drives a stray 9 DIV 3 sampled at edge Tk.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] exp, input bit early, input int poke,
                        input string tag);
      int lat;
      lat = (early && EARLY_BUILD) ? 1 : 33;
      bus.enable_div = 1'b1;
      bus.oper_a     = a;
      bus.oper_b     = b;
      bus.operation  = op;
      @(posedge clk);
      @(negedge clk);
      bus.enable_div = 1'b0;
      bus.oper_a     = $urandom;
      bus.oper_b     = $urandom;
      bus.operation  = 1'($urandom);
      for (int k = 1; k <= lat; k++) begin
         chk({tag, "_busy"}, {30'b0, bus.div_busy, bus.div_valid}, 32'b10);
         if (k == poke) begin
            bus.enable_div = 1'b1;
            bus.oper_a     = 32'd9;
            bus.oper_b     = 32'd3;
            bus.operation  = 1'b0;
         end else begin
            bus.enable_div = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus.enable_div = 1'b0;
      chk({tag, "_done"}, {30'b0, bus.div_busy, bus.div_valid}, 32'b01);
      chk({tag, "_res"}, bus.div_o, exp);
   endtask

   task automatic idle_check(input logic [31:0] exp, input string tag);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_pulse"}, {30'b0, bus.div_busy, bus.div_valid}, 32'b00);
      chk({tag, "_hold"}, bus.div_o, exp);
   endtask

   initial begin
      bus.enable_div = 1'b0;
      bus.operation  = 1'b0;
      bus.oper_a     = '0;
      bus.oper_b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_div_o", bus.div_o, 32'h0);
      chk("rst_busy", 32'(bus.div_busy), 32'h0);
      chk("rst_valid", 32'(bus.div_valid), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 0, "div_100_7");
      idle_check(32'd14, "div_100_7");
      do_op(32'd100, 32'd7, 1'b1, 32'd2, 1'b0, 0, "rem_100_7");
      idle_check(32'd2, "rem_100_7");
      do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, 0, "div_m7_2");
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, "rem_m7_2");
      do_op(32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 1'b0, 0, "div_7_m2");
      do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 1'b0, 0, "rem_7_m2");
      do_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 0, "div_by0");
      do_op(32'd5, 32'd0, 1'b1, 32'd5, 1'b1, 0, "rem_by0");
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 0, "div_ovf");
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 0, "rem_ovf");
      do_op(32'd3, 32'd10, 1'b0, 32'h0, 1'b1, 0, "div_small");
      do_op(32'hFFFF_FFFD, 32'd10, 1'b1, 32'hFFFF_FFFD, 1'b1, 0, "rem_small");
      idle_check(32'hFFFF_FFFD, "rem_small");

      do_op(32'd1000, 32'd3, 1'b0, 32'd333, 1'b0, 10, "div_ignore");
      seen_valid = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.div_valid === 1'b1) seen_valid++;
      end
      chk("ignore_no_2nd_valid", 32'(seen_valid), 32'd0);
      chk("ignore_hold", bus.div_o, 32'd333);

      bus.enable_div = 1'b1;
      bus.oper_a     = 32'd5000;
      bus.oper_b     = 32'd7;
      bus.operation  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.enable_div = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("midop_busy", 32'(bus.div_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("abort_div_o", bus.div_o, 32'h0);
      chk("abort_busy", 32'(bus.div_busy), 32'h0);
      chk("abort_valid", 32'(bus.div_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(32'd81, 32'd9, 1'b0, 32'd9, 1'b0, 0, "div_81_9");
      idle_check(32'd9, "div_81_9");

      do_op(32'd20, 32'd6, 1'b1, 32'd2, 1'b0, 0, "b2b_rem_20_6");
      t_first = cyc;
      do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 0, "b2b_div_max");
      chk("b2b_spacing", 32'(cyc - t_first), 32'd34);
      idle_check(32'h7FFF_FFFF, "b2b_div_max");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
